// File: rtl/gals_consumer_pkg.sv
// Shared definitions for the consumer-side buffer controller.
package gals_consumer_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/gals_consumer_hold_timer.sv
// Loadable down-counter shared by the hold period and the read-response timeout.
//  clock, reset : clock, asynchronous active-low reset
//  load/load_val: load the counter (load wins over dec)
//  dec          : count down by one, saturating at zero
//  done_c       : counter is zero (combinational)
module gals_consumer_hold_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/gals_consumer.sv
// Read-side controller: pops words from the buffer, presents each for a
// programmable hold time, counts words, flags errors and signals drain completion.
//  clock, reset : clock, asynchronous active-low reset
//  en, drain_req: consumption permitted / stop requested (short holds)
//  prog         : hold exponent, hold = HOLD_BASE << prog, sampled at capture
//  buf_*        : buffer read port (empty flag, pop request, response)
//  out_data/out_new/parity : presented word, update pulse, even parity
//  word_count, busy, drained, err : status outputs
module gals_consumer
  import gals_consumer_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned HOLD_BASE = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              drain_req,
  input  logic [2:0]        prog,
  input  logic              buf_empty,
  input  logic              buf_valid,
  input  logic [DATA_W-1:0] buf_data,
  output logic              buf_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_new,
  output logic              parity,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              drained,
  output logic              err
);

  localparam int unsigned HOLD_W = CNT_W + 8;

  state_t             state, state_n;
  logic               drain_q;
  logic               want_c;
  logic               capture;
  logic               drained_n;
  logic               err_n;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_done_c;
  logic [HOLD_W-1:0]  tmr_val;
  logic [HOLD_W-1:0]  hold_len;

  assign want_c   = (en | drain_req) & ~buf_empty;
  assign hold_len = drain_req ? HOLD_W'(1) : (HOLD_W'(HOLD_BASE) << prog);

  gals_consumer_hold_timer #(.W(HOLD_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done_c   (tmr_done_c)
  );

  // Next-state and pulse decode. The first HOLD cycle presents the freshly
  // captured word; the loaded hold count runs after it, so a word occupies
  // HOLD+1 cycles in S_HOLD and the word period is HOLD+3.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    capture   = 1'b0;
    drained_n = 1'b0;
    err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        err_n = buf_valid;
        if (want_c) begin
          state_n = S_FETCH;
        end else if (drain_req) begin
          drained_n = 1'b1;
        end
      end
      S_FETCH: begin
        err_n    = buf_valid;
        tmr_load = 1'b1;
        tmr_val  = HOLD_W'(TIMEOUT - 1);
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        // A response wins over buf_empty: the word has already left the buffer.
        if (buf_valid) begin
          capture  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = hold_len;
          state_n  = S_HOLD;
        end else if (tmr_done_c) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_HOLD: begin
        err_n = buf_valid;
        if (tmr_done_c) begin
          state_n = want_c ? S_FETCH : S_IDLE;
        end else if (drain_req && !drain_q) begin
          // Drain request arriving mid-hold: one more cycle, then leave.
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, capture register, counter and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      drain_q    <= 1'b0;
      buf_rd     <= 1'b0;
      out_data   <= '0;
      out_new    <= 1'b0;
      parity     <= 1'b0;
      word_count <= '0;
      busy       <= 1'b0;
      drained    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state   <= state_n;
      drain_q <= drain_req;
      buf_rd  <= (state_n == S_FETCH);
      busy    <= (state_n != S_IDLE);
      out_new <= capture;
      drained <= drained_n;
      err     <= err_n;
      if (capture) begin
        out_data   <= buf_data;
        parity     <= ^buf_data;
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gals_consumer.sv
// Self-checking bench for gals_consumer: buffer responder, scoreboard of
// expected presented words, table of words with expected parity, and
// hand-written sequences for reset, hold timing, timeout, drain and wrap.
module tb_gals_consumer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  logic              clock;
  logic              reset;
  logic              en;
  logic              drain_req;
  logic [2:0]        prog;
  logic              buf_empty;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              buf_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_new;
  logic              parity;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              drained;
  logic              err;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par;
  } vec_t;

  vec_t              tbl [7];
  vec_t              sb [$];
  logic [DATA_W-1:0] bufq [$];
  int                new_cyc [$];
  int                rd_cyc [$];
  int                err_cyc [$];
  int                drn_cyc [$];
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  int                vdelay = 1;
  logic [CNT_W-1:0]  exp_count = '0;
  logic [DATA_W-1:0] last_data = '0;

  gals_consumer #(
    .DATA_W(16), .HOLD_BASE(4), .CNT_W(8), .TIMEOUT(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .drain_req  (drain_req),
    .prog       (prog),
    .buf_empty  (buf_empty),
    .buf_valid  (buf_valid),
    .buf_data   (buf_data),
    .buf_rd     (buf_rd),
    .out_data   (out_data),
    .out_new    (out_new),
    .parity     (parity),
    .word_count (word_count),
    .busy       (busy),
    .drained    (drained),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input vec_t v, input bit push_sb);
    bufq.push_back(v.data);
    buf_empty = 1'b0;
    if (push_sb) sb.push_back(v);
  endtask

  function automatic int evt_count(input int kind);
    case (kind)
      0:       return new_cyc.size();
      1:       return err_cyc.size();
      default: return drn_cyc.size();
    endcase
  endfunction

  // Wait (bounded) until event queue 'kind' holds at least n entries.
  task automatic wait_evt(input int kind, input int n, input int budget);
    int k;
    k = 0;
    while (evt_count(kind) < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (evt_count(kind) < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_evt%0d: got %0d events, expected %0d", kind, evt_count(kind), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || buf_rd !== 1'b0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("wait_idle", 32'(busy), 0);
  endtask

  task automatic clear_log();
    new_cyc.delete();
    rd_cyc.delete();
    err_cyc.delete();
    drn_cyc.delete();
  endtask

  // Buffer model: pops on buf_rd, answers one cycle later unless vdelay==0.
  initial begin : responder
    logic [DATA_W-1:0] w;
    buf_valid = 1'b0;
    buf_data  = '0;
    buf_empty = 1'b1;
    forever begin
      @(negedge clock);
      if (buf_rd === 1'b1) begin
        w = (bufq.size() > 0) ? bufq.pop_front() : '0;
        @(posedge clock);
        #1;
        buf_empty = (bufq.size() == 0);
        if (vdelay == 1) begin
          buf_valid = 1'b1;
          buf_data  = w;
          @(posedge clock);
          #1;
          buf_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard compare on each out_new, event time-stamping.
  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        if (out_new === 1'b1) begin
          new_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            chk("sb_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("parity", 32'(parity), 32'(e.par));
            last_data = e.data;
          end
          exp_count = exp_count + CNT_W'(1);
          chk("word_count", 32'(word_count), 32'(exp_count));
        end
        if (buf_rd === 1'b1)  rd_cyc.push_back(cyc);
        if (err === 1'b1)     err_cyc.push_back(cyc);
        if (drained === 1'b1) drn_cyc.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    int   n;
    tbl[0] = '{16'h0003, 1'b0};
    tbl[1] = '{16'h0005, 1'b0};
    tbl[2] = '{16'h0008, 1'b1};
    tbl[3] = '{16'hFFFF, 1'b0};
    tbl[4] = '{16'h8001, 1'b0};
    tbl[5] = '{16'h1234, 1'b1};
    tbl[6] = '{16'h0007, 1'b1};

    reset = 1'b0; en = 1'b0; drain_req = 1'b0; prog = 3'd0;
    repeat (3) @(negedge clock);
    chk("reset_flags", 32'({buf_rd, out_new, parity, busy, drained, err}), 0);
    chk("reset_data", 32'(out_data), 0);
    chk("reset_count", 32'(word_count), 0);
    reset = 1'b1;
    @(negedge clock);

    // Reset asserted in the middle of a long hold.
    load('{16'h1234, 1'b1}, 1'b1);
    prog = 3'd3;
    en   = 1'b1;
    wait_evt(0, 1, 20);
    en = 1'b0;
    repeat (4) @(negedge clock);
    chk("t1_busy_before", 32'(busy), 1);
    chk("t1_data_before", 32'(out_data), 32'h1234);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_flags", 32'({buf_rd, out_new, parity, busy, drained, err}), 0);
    chk("t1_async_data", 32'(out_data), 0);
    chk("t1_async_count", 32'(word_count), 0);
    @(negedge clock);
    chk("t1_busy_after_edge", 32'(busy), 0);
    reset = 1'b1;
    exp_count = '0;
    clear_log();
    @(negedge clock);

    // Table of words at prog=0: period 7, latency 2 from buf_rd.
    for (int i = 0; i < 7; i++) load(tbl[i], 1'b1);
    prog = 3'd0;
    en   = 1'b1;
    wait_evt(0, 7, 200);
    en = 1'b0;
    if (new_cyc.size() >= 7) begin
      for (int i = 1; i < 7; i++) chk("t2_period", new_cyc[i] - new_cyc[i-1], 7);
    end
    if (rd_cyc.size() > 0 && new_cyc.size() > 0) chk("t2_latency", new_cyc[0] - rd_cyc[0], 2);
    wait_idle(50);
    chk("t2_count", 32'(word_count), 7);

    // prog=2 at capture, changed to 0 mid-hold; then en dropped mid-hold.
    clear_log();
    load('{16'hA5A5, 1'b0}, 1'b1);
    load('{16'h0001, 1'b1}, 1'b1);
    v = '{16'h0F00, 1'b0};
    load(v, 1'b0);
    prog = 3'd2;
    en   = 1'b1;
    wait_evt(0, 1, 20);
    repeat (3) @(negedge clock);
    prog = 3'd0;
    wait_evt(0, 2, 60);
    en = 1'b0;
    if (new_cyc.size() >= 2) chk("t3_hold16_period", new_cyc[1] - new_cyc[0], 19);
    wait_idle(20);
    chk("t3_word_left", bufq.size(), 1);
    chk("t3_data_retained", 32'(out_data), 32'h0001);
    chk("t3_no_extra_word", new_cyc.size(), 2);

    // Response never returns: the remaining word times out.
    clear_log();
    vdelay = 0;
    en = 1'b1;
    wait_evt(1, 1, 40);
    en = 1'b0;
    if (err_cyc.size() > 0 && rd_cyc.size() > 0) chk("t4_err_time", err_cyc[0] - rd_cyc[0], 5);
    wait_idle(20);
    repeat (3) @(negedge clock);
    chk("t4_err_once", err_cyc.size(), 1);
    chk("t4_count_kept", 32'(word_count), 9);
    chk("t4_no_word", new_cyc.size(), 0);
    vdelay = 1;

    // Drain with en=0: short holds, then drained repeats while empty.
    clear_log();
    load('{16'h00F0, 1'b0}, 1'b1);
    load('{16'h0700, 1'b1}, 1'b1);
    prog = 3'd5;
    drain_req = 1'b1;
    wait_evt(2, 2, 60);
    drain_req = 1'b0;
    if (new_cyc.size() >= 2) chk("t5_drain_period", new_cyc[1] - new_cyc[0], 4);
    if (new_cyc.size() >= 2 && drn_cyc.size() >= 2) begin
      chk("t5_drained_time", drn_cyc[0] - new_cyc[1], 3);
      chk("t5_drained_repeat", drn_cyc[1] - drn_cyc[0], 1);
    end
    wait_idle(20);
    @(negedge clock);
    chk("t5_drained_stops", 32'(drained), 0);

    // Fill the counter to 8'hFF, then one more word wraps it.
    clear_log();
    n = 255 - int'(exp_count);
    for (int i = 0; i < n; i++) begin
      v.data = DATA_W'($urandom_range(0, 65535));
      v.par  = ^v.data;
      load(v, 1'b1);
    end
    drain_req = 1'b1;
    wait_evt(0, n, 4 * n + 100);
    drain_req = 1'b0;
    wait_idle(20);
    chk("t6_count_ff", 32'(word_count), 32'hFF);
    clear_log();
    load('{16'hC3C1, 1'b1}, 1'b1);
    drain_req = 1'b1;
    wait_evt(0, 1, 20);
    drain_req = 1'b0;
    wait_idle(20);
    chk("t6_count_wrap", 32'(word_count), 0);

    // Unsolicited response while idle.
    @(negedge clock);
    buf_valid = 1'b1;
    buf_data  = 16'hDEAD;
    @(negedge clock);
    buf_valid = 1'b0;
    chk("t6_unsol_err", 32'(err), 1);
    chk("t6_unsol_data", 32'(out_data), 32'hC3C1);
    chk("t6_unsol_no_new", 32'(out_new), 0);
    chk("t6_unsol_idle", 32'(busy), 0);
    @(negedge clock);
    chk("t6_err_pulse", 32'(err), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
